// File: rtl/chaser_cmd_master_pkg.sv
// Shared types and byte codes for the chaser command master.
// The FSM states, the command/response alphabet and the status decode live here.
package chaser_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_GAP,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
  localparam logic [7:0] CMD_POLL    = 8'h50;  // 'P'

  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_DONE    = 8'h44;  // 'D'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'
  localparam logic [7:0] RSP_ERROR   = 8'h45;  // 'E'
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'

  // Only the low five bits of the chaser status word carry meaning.
  function automatic logic [7:0] status_byte(input logic [4:0] status);
    return {3'b000, status};
  endfunction

endpackage

// File: rtl/chaser_cmd_master_if.sv
// Command/response byte streams plus the Wishbone master bus of the chaser command master.
// The master modport is the design's view; the slave modport is the environment's view.
interface chaser_cmd_master_if;

  logic        i_cmd_valid;
  logic [7:0]  i_cmd_data;
  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic        i_rsp_ready;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic        o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
  logic        o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_data, i_rsp_ready, i_wb_stall, i_wb_ack, i_wb_data,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_wb_cyc, o_wb_stb, o_wb_we,
           o_wb_addr, o_wb_data, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_data, i_rsp_ready, i_wb_stall, i_wb_ack, i_wb_data,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_wb_cyc, o_wb_stb, o_wb_we,
           o_wb_addr, o_wb_data, o_busy
  );

endinterface

// File: rtl/chaser_cmd_master_wb_single_xfer.sv
// One pipelined Wishbone transfer: strobe until accepted, wait for ack, abort on timeout.
// The caller's FSM owns the request/wait phases; this block owns bus signalling and the timer.
module wb_single_xfer #(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        req,
  input  logic        pend,
  input  logic        we,
  input  logic        wb_stall,
  input  logic        wb_ack,
  input  logic [31:0] wb_rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic        accept,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(ACK_TIMEOUT);

  logic [TW-1:0] timer_reg, timer_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          active;

  always_comb begin
    active  = req || pend;
    // Reaching the limit removes cyc/stb in that very cycle, so the slave never sees a
    // strobe or cycle past the budget.
    timeout = active && (timer_reg == TIMER_LIMIT);
    wb_cyc  = active && !timeout;
    wb_stb  = req && !timeout;
    wb_we   = wb_cyc && we;
    accept  = wb_stb && !wb_stall;
    // An ack is only meaningful for an outstanding transfer or one accepted this cycle.
    done    = wb_cyc && wb_ack && (pend || accept);
    rdata   = done ? wb_rdata : rdata_reg;
  end

  always_comb begin
    timer_next = timer_reg;
    rdata_next = rdata_reg;
    if (start) begin
      timer_next = '0;
    end else if (active && !timeout) begin
      timer_next = timer_reg + 1'b1;
    end
    if (done && !we) begin
      rdata_next = wb_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
      rdata_reg <= '0;
    end else begin
      timer_reg <= timer_next;
      rdata_reg <= rdata_next;
    end
  end

endmodule

// File: rtl/chaser_cmd_master.sv
// Byte-command Wishbone master for the LED chaser: write, read and write-then-poll
// commands, one response byte per command, with timeout recovery on every transfer.
module chaser_cmd_master
  import chaser_cmd_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024,
  parameter int POLL_GAP    = 256,
  parameter int POLL_MAX    = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  chaser_cmd_master_if.master  bus
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  state_t        state_reg, state_next;
  logic [7:0]    cmd_reg, cmd_next;
  logic [7:0]    rsp_reg, rsp_next;
  logic [PW-1:0] poll_reg, poll_next;
  logic [GW-1:0] gap_reg, gap_next;

  logic          xfer_start, xfer_req, xfer_pend, xfer_we;
  logic          xfer_accept, xfer_done, xfer_timeout;
  logic [31:0]   xfer_rdata;
  logic          unused_rdata_bits;

  assign xfer_req  = (state_reg == ST_WR_REQ)  || (state_reg == ST_RD_REQ);
  assign xfer_pend = (state_reg == ST_WR_WAIT) || (state_reg == ST_RD_WAIT);
  assign xfer_we   = (state_reg == ST_WR_REQ)  || (state_reg == ST_WR_WAIT);
  // The timer restarts on the cycle that enters a request state from anywhere else.
  assign xfer_start = ((state_next == ST_WR_REQ) || (state_next == ST_RD_REQ)) && !xfer_req;
  assign unused_rdata_bits = ^xfer_rdata[31:5];

  wb_single_xfer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_xfer (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .start    (xfer_start),
    .req      (xfer_req),
    .pend     (xfer_pend),
    .we       (xfer_we),
    .wb_stall (bus.i_wb_stall),
    .wb_ack   (bus.i_wb_ack),
    .wb_rdata (bus.i_wb_data),
    .wb_cyc   (bus.o_wb_cyc),
    .wb_stb   (bus.o_wb_stb),
    .wb_we    (bus.o_wb_we),
    .accept   (xfer_accept),
    .done     (xfer_done),
    .timeout  (xfer_timeout),
    .rdata    (xfer_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    rsp_next   = rsp_reg;
    poll_next  = poll_reg;
    gap_next   = gap_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          cmd_next  = bus.i_cmd_data;
          poll_next = '0;
          case (bus.i_cmd_data)
            CMD_WRITE, CMD_POLL: state_next = ST_WR_REQ;
            CMD_READ:            state_next = ST_RD_REQ;
            default: begin
              state_next = ST_RESP;
              rsp_next   = RSP_UNKNOWN;
            end
          endcase
        end
      end

      ST_WR_REQ, ST_WR_WAIT: begin
        if (xfer_timeout) begin
          state_next = ST_RESP;
          rsp_next   = RSP_ERROR;
        end else if (xfer_done) begin
          if (cmd_reg == CMD_POLL) begin
            state_next = ST_GAP;
            gap_next   = '0;
          end else begin
            state_next = ST_RESP;
            rsp_next   = RSP_OK;
          end
        end else if ((state_reg == ST_WR_REQ) && xfer_accept) begin
          state_next = ST_WR_WAIT;
        end
      end

      ST_RD_REQ, ST_RD_WAIT: begin
        if (xfer_timeout) begin
          state_next = ST_RESP;
          rsp_next   = RSP_ERROR;
        end else if (xfer_done) begin
          if (cmd_reg == CMD_READ) begin
            state_next = ST_RESP;
            rsp_next   = status_byte(xfer_rdata[4:0]);
          end else if (xfer_rdata[4:0] == 5'd0) begin
            state_next = ST_RESP;
            rsp_next   = RSP_DONE;
          end else if (poll_reg == POLL_LIMIT) begin
            state_next = ST_RESP;
            rsp_next   = RSP_TIMEOUT;
          end else begin
            state_next = ST_GAP;
            poll_next  = poll_reg + 1'b1;
            gap_next   = '0;
          end
        end else if ((state_reg == ST_RD_REQ) && xfer_accept) begin
          state_next = ST_RD_WAIT;
        end
      end

      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_RD_REQ;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= '0;
      rsp_reg   <= '0;
      poll_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      rsp_reg   <= rsp_next;
      poll_reg  <= poll_next;
      gap_reg   <= gap_next;
    end
  end

  assign bus.o_cmd_ready = (state_reg == ST_IDLE);
  assign bus.o_rsp_valid = (state_reg == ST_RESP);
  assign bus.o_rsp_data  = rsp_reg;
  assign bus.o_busy      = (state_reg != ST_IDLE);
  assign bus.o_wb_addr   = 1'b0;
  assign bus.o_wb_data   = '0;

endmodule

// File: tb/tb_chaser_cmd_master.sv
// Directed bench for chaser_cmd_master with a small Wishbone slave model
// (registered or same-cycle ack, stall control, scripted status words).
module tb_chaser_cmd_master;
  import chaser_cmd_master_pkg::*;

  localparam int T_ACK  = 16;
  localparam int T_GAP  = 8;
  localparam int T_PMAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chaser_cmd_master_if ifc();

  chaser_cmd_master #(
    .ACK_TIMEOUT (T_ACK),
    .POLL_GAP    (T_GAP),
    .POLL_MAX    (T_PMAX)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifc.master)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Slave model state
  bit          ack_en    = 1'b1;
  bit          ack_comb  = 1'b0;
  bit          clr_stats = 1'b0;
  logic        ack_q     = 1'b0;
  logic [31:0] rd_q      = '0;
  logic [31:0] rd_seq [8];
  logic [31:0] rd_word;
  int          rd_len    = 1;
  int          rd_idx    = 0;
  int          wr_cnt    = 0;
  int          rd_cnt    = 0;
  int          cyc_cycles = 0;
  int          idle_run  = 0;
  int          min_gap   = 1000;
  logic [31:0] wr_data_last = 32'hFFFF_FFFF;

  always_comb rd_word = rd_seq[(rd_idx < rd_len) ? rd_idx : rd_len - 1];

  assign ifc.i_wb_data = rd_q;
  assign ifc.i_wb_ack  = ack_q | (ack_comb & ifc.o_wb_cyc & ifc.o_wb_stb & ~ifc.i_wb_stall);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else if (clr_stats) begin
      ack_q        <= 1'b0;
      wr_cnt       <= 0;
      rd_cnt       <= 0;
      rd_idx       <= 0;
      cyc_cycles   <= 0;
      idle_run     <= 0;
      min_gap      <= 1000;
      wr_data_last <= 32'hFFFF_FFFF;
    end else begin
      ack_q    <= 1'b0;
      idle_run <= ifc.o_wb_cyc ? 0 : idle_run + 1;
      if (ifc.o_wb_cyc) cyc_cycles <= cyc_cycles + 1;
      if (ifc.o_wb_cyc && ifc.o_wb_stb && !ifc.i_wb_stall) begin
        ack_q <= ack_en && !ack_comb;
        if (ifc.o_wb_we) begin
          wr_cnt       <= wr_cnt + 1;
          wr_data_last <= ifc.o_wb_data;
        end else begin
          rd_cnt <= rd_cnt + 1;
          rd_idx <= rd_idx + 1;
          rd_q   <= rd_word;
          if (idle_run < min_gap) min_gap <= idle_run;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    while (!ifc.o_cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready wait", 32'(waited < 200), 32'd1);
    ifc.i_cmd_valid = 1'b1;
    ifc.i_cmd_data  = b;
    @(posedge clk);
    #1 ifc.i_cmd_valid = 1'b0;
  endtask

  // Returns the cycle number (1 = first cycle after acceptance) where rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!ifc.o_rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid wait", 32'(lat < 2000), 32'd1);
  endtask

  task automatic take_rsp();
    ifc.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifc.i_rsp_ready = 1'b0;
    @(negedge clk);
    check("cmd_ready after rsp", 32'(ifc.o_cmd_ready), 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] b, input logic [7:0] exp_rsp,
                        output int lat);
    send_cmd(b);
    wait_rsp(lat);
    $display("%s: cmd 0x%02h -> rsp 0x%02h at cycle %0d (wr %0d rd %0d)",
             tag, b, ifc.o_rsp_data, lat, wr_cnt, rd_cnt);
    check({tag, " rsp"}, 32'(ifc.o_rsp_data), 32'(exp_rsp));
    take_rsp();
  endtask

  initial begin
    int  lat;
    bit  stable;
    bit  saw_rsp;

    ifc.i_cmd_valid = 1'b0;
    ifc.i_cmd_data  = 8'h00;
    ifc.i_rsp_ready = 1'b0;
    ifc.i_wb_stall  = 1'b0;
    for (int i = 0; i < 8; i++) rd_seq[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset cyc",       32'(ifc.o_wb_cyc),    32'd0);
    check("reset stb",       32'(ifc.o_wb_stb),    32'd0);
    check("reset we",        32'(ifc.o_wb_we),     32'd0);
    check("reset rsp_valid", 32'(ifc.o_rsp_valid), 32'd0);
    check("reset busy",      32'(ifc.o_busy),      32'd0);
    check("reset rsp_data",  32'(ifc.o_rsp_data),  32'h00);
    check("reset cmd_ready", 32'(ifc.o_cmd_ready), 32'd1);
    rst_n = 1'b1;

    // 'W', registered ack: REQ, WAIT, RESP
    clear_stats();
    do_cmd("W", CMD_WRITE, 8'h4B, lat);
    check("W latency",  32'(lat),       32'd3);
    check("W writes",   32'(wr_cnt),    32'd1);
    check("W reads",    32'(rd_cnt),    32'd0);
    check("W data",     wr_data_last,   32'h0);

    // 'W', ack in the acceptance cycle skips WAIT
    clear_stats();
    ack_comb = 1'b1;
    do_cmd("W fast ack", CMD_WRITE, 8'h4B, lat);
    ack_comb = 1'b0;
    check("W fast latency", 32'(lat),    32'd2);
    check("W fast writes",  32'(wr_cnt), 32'd1);

    // 'R' returns status byte
    clear_stats();
    rd_seq[0] = 32'h0000_0007;
    rd_len    = 1;
    do_cmd("R", CMD_READ, 8'h07, lat);
    check("R reads",  32'(rd_cnt), 32'd1);
    check("R writes", 32'(wr_cnt), 32'd0);

    // 'P' with status 5, 3, 0
    clear_stats();
    rd_seq[0] = 32'd5;
    rd_seq[1] = 32'd3;
    rd_seq[2] = 32'd0;
    rd_len    = 3;
    do_cmd("P", CMD_POLL, 8'h44, lat);
    check("P writes",  32'(wr_cnt), 32'd1);
    check("P reads",   32'(rd_cnt), 32'd3);
    check("P gap>=POLL_GAP", 32'(min_gap >= T_GAP), 32'd1);

    // 'W' against a permanently stalled slave times out
    clear_stats();
    ifc.i_wb_stall = 1'b1;
    do_cmd("W stalled", CMD_WRITE, 8'h45, lat);
    check("stall cyc cycles", 32'(cyc_cycles), 32'(T_ACK));
    check("stall writes",     32'(wr_cnt),     32'd0);
    ifc.i_wb_stall = 1'b0;

    // Recovery: next 'R' works, only low five status bits returned
    clear_stats();
    rd_seq[0] = 32'hABCD_0033;
    rd_len    = 1;
    do_cmd("R after timeout", CMD_READ, 8'h13, lat);
    check("R after timeout reads", 32'(rd_cnt), 32'd1);

    // 'P' with status stuck nonzero hits the poll limit
    clear_stats();
    rd_seq[0] = 32'd9;
    rd_len    = 1;
    do_cmd("P stuck", CMD_POLL, 8'h54, lat);
    check("P stuck reads",  32'(rd_cnt), 32'(T_PMAX + 1));
    check("P stuck writes", 32'(wr_cnt), 32'd1);

    // Unknown command with response back-pressure
    clear_stats();
    send_cmd(8'h41);
    wait_rsp(lat);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.o_rsp_data !== 8'h3F || !ifc.o_rsp_valid || ifc.o_cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    $display("unknown: cmd 0x41 -> rsp 0x%02h held, stable=%0d", ifc.o_rsp_data, stable);
    check("unknown rsp held", 32'(stable), 32'd1);
    check("unknown rsp",      32'(ifc.o_rsp_data), 32'h3F);
    take_rsp();
    check("unknown bus idle", 32'(wr_cnt + rd_cnt + cyc_cycles), 32'd0);

    // Reset in the middle of WR_WAIT
    clear_stats();
    ack_en = 1'b0;
    send_cmd(CMD_WRITE);
    @(negedge clk);
    @(negedge clk);
    check("wait cyc",  32'(ifc.o_wb_cyc), 32'd1);
    check("wait stb",  32'(ifc.o_wb_stb), 32'd0);
    check("wait we",   32'(ifc.o_wb_we),  32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset cyc",  32'(ifc.o_wb_cyc), 32'd0);
    check("async reset busy", 32'(ifc.o_busy),   32'd0);
    $display("reset mid WR_WAIT: cyc=%0d busy=%0d", ifc.o_wb_cyc, ifc.o_busy);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.o_rsp_valid) saw_rsp = 1'b1;
    end
    check("no rsp after reset",  32'(saw_rsp),          32'd0);
    check("cmd_ready after rst", 32'(ifc.o_cmd_ready),  32'd1);
    check("rsp_data after rst",  32'(ifc.o_rsp_data),   32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
